// File: rtl/imem_loader_arbiter.sv
// Instruction-memory port arbiter: the IF stage reads in RUN; a streaming
// loader owns the write port in LOAD; FLUSH is a one-cycle handover back to the CPU.
module imem_loader_arbiter #(
  parameter int MEM_SIZE = 512,
  parameter int AW       = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic [31:0]   fetch_addr,
  output logic [31:0]   fetch_instr,
  output logic          fetch_valid,
  output logic          cpu_hold,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          load_done,
  output logic [AW:0]   load_count,
  output logic          overflow,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(MEM_SIZE - 1);

  state_t        state;
  logic [AW-1:0] wptr;
  logic          accept;

  // Handshake: a loader word moves on any cycle where load_valid and
  // load_ready are both high; load_ready is high for every LOAD cycle.
  assign accept = load_valid && load_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      wptr       <= '0;
      load_count <= '0;
      overflow   <= 1'b0;
      load_done  <= 1'b0;
      load_ready <= 1'b0;
      cpu_hold   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (load_start) begin
            state      <= LOAD;
            wptr       <= '0;
            load_count <= '0;
            overflow   <= 1'b0;
            load_ready <= 1'b1;
            cpu_hold   <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            wptr       <= wptr + AW'(1);
            load_count <= load_count + (AW+1)'(1);
            // The image ends on an explicit last word or when memory is full;
            // filling memory without a last word flags overflow.
            if (load_last || (wptr == LAST_IDX)) begin
              state      <= FLUSH;
              load_ready <= 1'b0;
              load_done  <= 1'b1;
              overflow   <= !load_last;
            end
          end
        end
        FLUSH: begin
          state     <= RUN;
          load_done <= 1'b0;
          cpu_hold  <= 1'b0;
        end
        default: begin
          state      <= RUN;
          load_done  <= 1'b0;
          load_ready <= 1'b0;
          cpu_hold   <= 1'b0;
        end
      endcase
    end
  end

  // Fetch path is purely combinational so RUN reads have zero latency.
  assign mem_addr    = (state == RUN) ? fetch_addr[AW+1:2] : wptr;
  assign mem_we      = (state == LOAD) && load_valid;
  assign mem_wdata   = load_data;
  assign fetch_valid = (state == RUN);
  assign fetch_instr = (state == RUN) ? mem_rdata : 32'h0;
  assign state_dbg   = state;

  logic unused_fetch_bits;
  assign unused_fetch_bits = ^{fetch_addr[31:AW+2], fetch_addr[1:0]};

endmodule

// File: tb/tb_imem_loader_arbiter.sv
// Directed bench for imem_loader_arbiter: bench-side memory, spec-level model
// checked every cycle, write scoreboard, and literal checks for key scenarios.
module tb_imem_loader_arbiter;

  localparam int MEM_SIZE = 512;
  localparam int AW       = 9;

  logic          clk;
  logic          reset;
  logic          load_start;
  logic          load_valid;
  logic [31:0]   load_data;
  logic          load_last;
  logic          load_ready;
  logic [31:0]   fetch_addr;
  logic [31:0]   fetch_instr;
  logic          fetch_valid;
  logic          cpu_hold;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          load_done;
  logic [AW:0]   load_count;
  logic          overflow;
  logic [1:0]    state_dbg;

  int total = 0;
  int bad   = 0;

  logic [31:0] tb_mem [MEM_SIZE];
  logic [31:0] m_img  [MEM_SIZE];
  logic [31:0] exp_q [$];

  // Model: 0 = running, 1 = loading, 2 = handover
  int m_mode  = 0;
  int m_ptr   = 0;
  int m_count = 0;
  bit m_ovf   = 1'b0;
  int cmp_idx;

  imem_loader_arbiter #(.MEM_SIZE(MEM_SIZE), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .fetch_addr  (fetch_addr),
    .fetch_instr (fetch_instr),
    .fetch_valid (fetch_valid),
    .cpu_hold    (cpu_hold),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .load_done   (load_done),
    .load_count  (load_count),
    .overflow    (overflow),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // ---------------- checker helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction memory + write scoreboard ----------------
  initial begin
    for (int i = 0; i < MEM_SIZE; i++) begin
      tb_mem[i] = 32'hA500_0000 + 32'(i);
      m_img[i]  = 32'hA500_0000 + 32'(i);
    end
  end

  assign mem_rdata = tb_mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", mem_wdata, 32'hxxxx_xxxx);
      end else begin
        chk("write_data", mem_wdata, exp_q.pop_front());
      end
      tb_mem[mem_addr] = mem_wdata;
    end
  end

  // ---------------- behavioural model ----------------
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_ptr = 0; m_count = 0; m_ovf = 1'b0;
    end else begin
      case (m_mode)
        0: if (load_start) begin
             m_mode = 1; m_ptr = 0; m_count = 0; m_ovf = 1'b0;
           end
        1: if (load_valid) begin
             m_img[m_ptr] = load_data;
             m_ptr++;
             m_count++;
             if (load_last) m_mode = 2;
             else if (m_ptr == MEM_SIZE) begin
               m_mode = 2;
               m_ovf  = 1'b1;
             end
           end
        default: m_mode = 0;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    cmp_idx = int'((fetch_addr >> 2) % MEM_SIZE);
    chk("fetch_valid", 32'(fetch_valid), 32'(m_mode == 0));
    chk("fetch_instr", fetch_instr, (m_mode == 0) ? tb_mem[cmp_idx] : 32'h0);
    chk("mem_addr", 32'(mem_addr), (m_mode == 0) ? 32'(cmp_idx) : 32'(m_ptr % MEM_SIZE));
    chk("mem_we", 32'(mem_we), 32'((m_mode == 1) && load_valid));
    chk("load_ready", 32'(load_ready), 32'(m_mode == 1));
    chk("cpu_hold", 32'(cpu_hold), 32'(m_mode != 0));
    chk("load_done", 32'(load_done), 32'(m_mode == 2));
    chk("load_count", 32'(load_count), 32'(m_count));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (m_mode == 1) chk("mem_wdata", mem_wdata, load_data);
  end

  // ---------------- driver tasks ----------------
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [31:0] d, input logic last, input bit v, input bit acc);
    load_valid = v;
    load_data  = d;
    load_last  = last;
    if (acc) exp_q.push_back(d);
  endtask

  logic [31:0] w3 [3];

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
    load_last = 1'b0; fetch_addr = 32'h0;
    w3[0] = 32'h2004_0020; w3[1] = 32'h2005_0000; w3[2] = 32'h1000_FFFF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_count", 32'(load_count), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    reset = 1'b1;
    adv();

    // Zero-latency fetch, with address wrap
    fetch_addr = 32'h0000_0018;
    @(negedge clk);
    chk("run_addr6", 32'(mem_addr), 32'd6);
    chk("run_instr6", fetch_instr, 32'hA500_0006);
    chk("run_valid", 32'(fetch_valid), 32'd1);
    chk("run_we", 32'(mem_we), 32'd0);
    adv();
    fetch_addr = 32'hFFFF_F81B;
    @(negedge clk);
    chk("wrap_addr", 32'(mem_addr), 32'd6);
    adv();
    fetch_addr = 32'h0;

    // Three-word image, back to back
    load_start = 1'b1;
    @(negedge clk);
    chk("start_still_run", 32'(fetch_valid), 32'd1);
    adv();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_word(w3[i], (i == 2), 1'b1, 1'b1);
      @(negedge clk);
      chk("l3_addr", 32'(mem_addr), 32'(i));
      chk("l3_we", 32'(mem_we), 32'd1);
      chk("l3_hold", 32'(cpu_hold), 32'd1);
      adv();
    end
    load_valid = 1'b0; load_last = 1'b0;
    @(negedge clk);
    chk("l3_done", 32'(load_done), 32'd1);
    chk("l3_count", 32'(load_count), 32'd3);
    chk("l3_flush_ready", 32'(load_ready), 32'd0);
    adv();
    @(negedge clk);
    chk("l3_hold_off", 32'(cpu_hold), 32'd0);
    chk("l3_done_off", 32'(load_done), 32'd0);
    chk("l3_fetch0", fetch_instr, 32'h2004_0020);
    chk("l3_count_hold", 32'(load_count), 32'd3);
    chk("l3_mem2", tb_mem[2], 32'h1000_FFFF);
    adv();

    // Gapped valid: 1-0-1-0-1
    load_start = 1'b1;
    adv();
    load_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_word(32'h3000_0000 + 32'(k), (k == 4), (k % 2 == 0), (k % 2 == 0));
      @(negedge clk);
      chk("gap_we", 32'(mem_we), 32'(k % 2 == 0));
      chk("gap_addr", 32'(mem_addr), 32'((k + 1) / 2));
      chk("gap_fetch_valid", 32'(fetch_valid), 32'd0);
      adv();
    end
    load_valid = 1'b0; load_last = 1'b0;
    @(negedge clk);
    chk("gap_count", 32'(load_count), 32'd3);
    adv(); adv();

    // Full memory without last -> overflow
    load_start = 1'b1;
    adv();
    load_start = 1'b0;
    for (int i = 0; i < MEM_SIZE; i++) begin
      drive_word(32'h1000_0000 + 32'(i), 1'b0, 1'b1, 1'b1);
      if (i == MEM_SIZE - 1) begin
        @(negedge clk);
        chk("ovf_last_addr", 32'(mem_addr), 32'd511);
      end
      adv();
    end
    drive_word(32'hDEAD_0000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(load_count), 32'd512);
    chk("ovf_ready", 32'(load_ready), 32'd0);
    chk("ovf_we", 32'(mem_we), 32'd0);
    chk("ovf_done", 32'(load_done), 32'd1);
    adv();
    load_valid = 1'b0;
    @(negedge clk);
    chk("ovf_run", 32'(state_dbg), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_mem511", tb_mem[511], 32'h1000_01FF);
    load_start = 1'b1;
    adv();
    load_start = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", 32'(overflow), 32'd0);
    chk("ovf_count_clr", 32'(load_count), 32'd0);
    drive_word(32'h1111_1111, 1'b1, 1'b1, 1'b1);
    adv();
    load_valid = 1'b0; load_last = 1'b0;
    adv(); adv();

    // Reset in the middle of a load
    load_start = 1'b1;
    adv();
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_word(32'hBEEF_0000 + 32'(i), 1'b0, 1'b1, 1'b1);
      adv();
    end
    drive_word(32'hBAD0_0005, 1'b0, 1'b1, 1'b0);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state_dbg), 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_count", 32'(load_count), 32'd0);
    chk("mid_rst_hold", 32'(cpu_hold), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    load_valid = 1'b0;
    adv();
    for (int i = 0; i < 5; i++) chk("mid_rst_kept", tb_mem[i], 32'hBEEF_0000 + 32'(i));
    chk("mid_rst_word5", tb_mem[5], 32'h1000_0005);

    // load_start together with a fetch of address 4
    fetch_addr = 32'h4;
    load_start = 1'b1;
    @(negedge clk);
    chk("same_cyc_fetch", fetch_instr, 32'hBEEF_0001);
    chk("same_cyc_valid", 32'(fetch_valid), 32'd1);
    adv();
    load_start = 1'b0;
    @(negedge clk);
    chk("next_cyc_state", 32'(state_dbg), 32'd1);
    chk("next_cyc_valid", 32'(fetch_valid), 32'd0);
    chk("next_cyc_instr", fetch_instr, 32'h0);
    drive_word(32'h0000_0013, 1'b1, 1'b1, 1'b1);
    adv();
    load_valid = 1'b0; load_last = 1'b0;
    adv(); adv();

    // Final memory image and scoreboard drain
    for (int i = 0; i < MEM_SIZE; i++) chk("final_image", tb_mem[i], m_img[i]);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
